// File: rtl/esd_pkg.sv
// Shared types and derived constants for the ESD heartbeat initiator.
package esd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_KICKING = 2'b01,
    ST_ACKING  = 2'b10,
    ST_STALLED = 2'b11
  } esd_state_e;

  localparam int KICK_CNT_W = 8;

  // Anything shorter than 4 clocks cannot be told apart from a stuck kick line.
  function automatic int kick_cycles(input int clk_hz, input int period_us);
    int c;
    c = (clk_hz / 1000000) * period_us;
    return (c < 4) ? 4 : c;
  endfunction

  function automatic int ack_cycles(input int n);
    return (n < 2) ? 2 : n;
  endfunction

endpackage

// File: rtl/esd_heartbeat_initiator_if.sv
// Application/controller-side signal bundle of the heartbeat initiator.
interface esd_heartbeat_initiator_if;
  import esd_pkg::*;

  logic                  enable;
  logic                  app_alive;
  logic                  app_fault;
  logic                  restart_req;
  logic                  shutdown_in;
  logic                  estop_clear;
  logic                  wdg_kick;
  logic                  ack_n;
  logic                  stalled;
  logic [1:0]            state;
  logic [KICK_CNT_W-1:0] kick_count;

  modport master (
    output enable, app_alive, app_fault, restart_req, shutdown_in, estop_clear,
    input  wdg_kick, ack_n, stalled, state, kick_count
  );

  modport slave (
    input  enable, app_alive, app_fault, restart_req, shutdown_in, estop_clear,
    output wdg_kick, ack_n, stalled, state, kick_count
  );

endinterface

// File: rtl/esd_interval_timer.sv
// Up-counter 0..CYCLES-1 with clear, enable and a terminal-count flag.
module esd_interval_timer #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            W    = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0]  LAST = W'(CYCLES - 1);

  logic [W-1:0] count_d, count_q;

  // tc does not depend on clr, so callers may derive clr from tc safely.
  always_comb begin
    tc      = en && (count_q == LAST);
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/esd_heartbeat_initiator.sv
// Watchdog-kick and restart-ACK source for the emergency shutdown controller.
// state   | meaning
// IDLE    | service disabled, no kicks
// KICKING | kick every interval while the application is alive
// ACKING  | ack_n held low for ACK_CYCLES, kicks continue
// STALLED | liveness lost or fault, waiting for restart_req
module esd_heartbeat_initiator
  import esd_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int KICK_PERIOD_US = 10000,
  parameter int ACK_CYCLES     = 100
) (
  input logic                       clk,
  input logic                       rst_n,
  esd_heartbeat_initiator_if.slave  bus
);

  localparam int KICK_CYC = kick_cycles(CLK_HZ, KICK_PERIOD_US);
  localparam int ACK_CYC  = ack_cycles(ACK_CYCLES);

  esd_state_e            state_d, state_q;
  logic                  alive_d, alive_q;
  logic                  kick_d, kick_q;
  logic                  ack_n_d, ack_n_q;
  logic                  stalled_d, stalled_q;
  logic [KICK_CNT_W-1:0] count_d, count_q;

  logic kick_tc, kick_en, kick_clr;
  logic ack_tc, ack_en, ack_clr;
  logic live;

  assign kick_en  = (state_q == ST_KICKING) || (state_q == ST_ACKING);
  assign kick_clr = !((state_d == ST_KICKING) || (state_d == ST_ACKING));
  assign ack_en   = (state_q == ST_ACKING);
  assign ack_clr  = (state_d != ST_ACKING);

  esd_interval_timer #(.CYCLES(KICK_CYC)) u_kick_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (kick_clr),
    .en    (kick_en),
    .tc    (kick_tc)
  );

  esd_interval_timer #(.CYCLES(ACK_CYC)) u_ack_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ack_clr),
    .en    (ack_en),
    .tc    (ack_tc)
  );

  always_comb begin
    live    = alive_q | bus.app_alive;
    state_d = state_q;
    kick_d  = 1'b0;
    count_d = count_q;
    alive_d = alive_q | bus.app_alive;

    if (!bus.enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_KICKING;
          alive_d = 1'b0;
        end
        ST_KICKING, ST_ACKING: begin
          if (bus.app_fault) begin
            state_d = ST_STALLED;
          end else if (kick_tc && !live) begin
            state_d = ST_STALLED;
          end else begin
            // A same-cycle app_alive counts toward the next interval.
            if (kick_tc) begin
              kick_d  = 1'b1;
              count_d = count_q + KICK_CNT_W'(1);
              alive_d = bus.app_alive;
            end
            if (state_q == ST_KICKING && bus.restart_req &&
                bus.shutdown_in && bus.estop_clear) begin
              state_d = ST_ACKING;
            end else if (state_q == ST_ACKING && ack_tc) begin
              state_d = ST_KICKING;
            end
          end
        end
        ST_STALLED: begin
          if (bus.restart_req && !bus.app_fault) begin
            state_d = ST_KICKING;
            alive_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    ack_n_d   = (state_d != ST_ACKING);
    stalled_d = (state_d == ST_STALLED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      alive_q   <= 1'b0;
      kick_q    <= 1'b0;
      ack_n_q   <= 1'b1;
      stalled_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      alive_q   <= alive_d;
      kick_q    <= kick_d;
      ack_n_q   <= ack_n_d;
      stalled_q <= stalled_d;
      count_q   <= count_d;
    end
  end

  assign bus.wdg_kick   = kick_q;
  assign bus.ack_n      = ack_n_q;
  assign bus.stalled    = stalled_q;
  assign bus.state      = state_q;
  assign bus.kick_count = count_q;

endmodule

// File: tb/tb_esd_heartbeat_initiator.sv
// Self-checking bench: randomized liveness/restart stimulus against a cycle model of the rules.
module tb_esd_heartbeat_initiator;
  import esd_pkg::*;

  localparam int KC = 50;
  localparam int AC = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  esd_heartbeat_initiator_if bus();

  esd_heartbeat_initiator #(
    .CLK_HZ(50000000), .KICK_PERIOD_US(1), .ACK_CYCLES(AC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: state 0=IDLE 1=KICKING 2=ACKING 3=STALLED
  int m_state, m_timer, m_ack, m_count;
  bit m_alive, m_kick, m_ackn;

  task automatic model_reset();
    m_state = 0; m_timer = 0; m_ack = 0; m_count = 0;
    m_alive = 0; m_kick = 0; m_ackn = 1;
  endtask

  task automatic model_clk();
    int ns;
    bit kick;
    kick = 0;
    ns = m_state;
    if (!bus.enable) ns = 0;
    else if (m_state == 0) ns = 1;
    else if (m_state == 3) begin
      if (bus.restart_req && !bus.app_fault) ns = 1;
    end else if (bus.app_fault) ns = 3;
    else begin
      if (m_timer == KC - 1) begin
        if (m_alive || bus.app_alive) kick = 1;
        else ns = 3;
      end
      if (ns != 3) begin
        if (m_state == 1 && bus.restart_req && bus.shutdown_in && bus.estop_clear) ns = 2;
        else if (m_state == 2 && m_ack == AC - 1) ns = 1;
      end
    end
    if ((ns == 1 || ns == 2) && (m_state == 1 || m_state == 2)) m_timer = (m_timer + 1) % KC;
    else m_timer = 0;
    m_ack = (ns == 2 && m_state == 2) ? m_ack + 1 : 0;
    if (ns == 1 && (m_state == 0 || m_state == 3)) m_alive = 0;
    else if (kick) m_alive = bus.app_alive;
    else m_alive = m_alive | bus.app_alive;
    m_kick = kick;
    if (kick) m_count = (m_count + 1) % 256;
    m_ackn = (ns != 2);
    m_state = ns;
  endtask

  function automatic logic [12:0] exp_vec();
    return {m_kick, m_ackn, (m_state == 3), 2'(m_state), 8'(m_count)};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {bus.wdg_kick, bus.ack_n, bus.stalled, bus.state, bus.kick_count};
  endfunction

  task automatic step();
    @(posedge clk);
    model_clk();
    #1;
    bus.app_alive   = 1'b0;
    bus.restart_req = 1'b0;
  endtask

  task automatic do_reset();
    bus.enable = 0; bus.app_alive = 0; bus.app_fault = 0;
    bus.restart_req = 0; bus.shutdown_in = 0; bus.estop_clear = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (obs_vec() !== 13'h0800) begin
      n_fail++; $display("FAIL reset_values got %h exp %h", obs_vec(), 13'h0800);
    end
  endtask

  task automatic test_kicking();
    int p, ph, last;
    p = $urandom_range(10, 25);
    ph = $urandom_range(0, 24);
    last = -1;
    bus.enable = 1;
    for (int i = 0; i <= 250; i++) begin
      bus.app_alive = ((i + ph) % p == 0);
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL kicking cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      if (bus.wdg_kick) begin
        if (last >= 0) begin
          n_tests++;
          if (i - last != KC) begin
            n_fail++; $display("FAIL kick_period got %0d exp %0d", i - last, KC);
          end
        end
        last = i;
      end
    end
    n_tests++;
    if (bus.kick_count !== 8'd5) begin
      n_fail++; $display("FAIL kick_count_250 got %0d exp 5", bus.kick_count);
    end
  endtask

  task automatic test_stall();
    int kicks, kicks2;
    bit hit;
    kicks = 0; kicks2 = 0; hit = 0;
    for (int i = 0; i < 3 * KC && !hit; i++) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stall_entry cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      if (bus.wdg_kick) kicks++;
      if (bus.state === 2'b11) hit = 1;
    end
    n_tests++;
    if (!hit || kicks > 1) begin
      n_fail++; $display("FAIL stall_reach got hit=%0d kicks=%0d exp hit=1 kicks<=1", hit, kicks);
    end
    for (int i = 0; i < 500; i++) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stalled_hold cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      if (bus.wdg_kick) kicks2++;
    end
    n_tests++;
    if (kicks2 != 0 || bus.stalled !== 1'b1 || bus.state !== 2'b11) begin
      n_fail++; $display("FAIL stalled_quiet got kicks=%0d stalled=%b state=%b exp 0 1 11",
                         kicks2, bus.stalled, bus.state);
    end
    bus.restart_req = 1;
    step();
    n_tests++;
    if (bus.state !== 2'b01 || bus.stalled !== 1'b0) begin
      n_fail++; $display("FAIL stall_restart got state=%b stalled=%b exp 01 0", bus.state, bus.stalled);
    end
    kicks = 0;
    for (int i = 0; i < 2 * KC; i++) begin
      bus.app_alive = (i % 15 == 0);
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL resume cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      if (bus.wdg_kick) kicks++;
    end
    n_tests++;
    if (kicks < 1) begin
      n_fail++; $display("FAIL resume_kicks got %0d exp >=1", kicks);
    end
  endtask

  task automatic test_ack();
    int low, kin;
    low = 0; kin = 0;
    bus.shutdown_in = 1; bus.estop_clear = 1;
    for (int i = 0; i < AC + 20; i++) begin
      bus.app_alive = (i % 15 == 0);
      if (i == 0) bus.restart_req = 1;
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL ack cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      if (i == 0) begin
        n_tests++;
        if (bus.ack_n !== 1'b0) begin
          n_fail++; $display("FAIL ack_latency got ack_n=%b exp 0", bus.ack_n);
        end
      end
      if (!bus.ack_n) begin
        low++;
        if (bus.wdg_kick) kin++;
      end
    end
    n_tests++;
    if (low != AC || kin < 1 || bus.state !== 2'b01) begin
      n_fail++; $display("FAIL ack_width got low=%0d kicks=%0d state=%b exp %0d >=1 01",
                         low, kin, bus.state, AC);
    end
  endtask

  task automatic test_ack_blocked();
    for (int k = 0; k < 2; k++) begin
      bus.shutdown_in = (k == 0);
      bus.estop_clear = (k == 1);
      for (int i = 0; i < 5; i++) begin
        bus.app_alive = (i == 0);
        bus.restart_req = (i == 0);
        step();
        n_tests++;
        if (bus.ack_n !== 1'b1 || bus.state !== 2'b01 || obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL ack_blocked k=%0d cyc %0d got %h exp %h", k, i, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_fault();
    int low;
    bus.shutdown_in = 1; bus.estop_clear = 1;
    bus.restart_req = 1;
    step();
    low = (bus.ack_n === 1'b0) ? 1 : 0;
    for (int i = 1; i < AC && low < 40; i++) begin
      bus.app_alive = (i % 15 == 0);
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL fault_pre cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      if (!bus.ack_n) low++;
    end
    bus.app_fault = 1;
    step();
    n_tests++;
    if (bus.ack_n !== 1'b1 || bus.state !== 2'b11 || low != 40) begin
      n_fail++; $display("FAIL fault_abort got ack_n=%b state=%b low=%0d exp 1 11 40",
                         bus.ack_n, bus.state, low);
    end
    bus.restart_req = 1;
    step();
    n_tests++;
    if (bus.state !== 2'b11) begin
      n_fail++; $display("FAIL fault_restart_ignored got state=%b exp 11", bus.state);
    end
    bus.app_fault = 0;
    bus.restart_req = 1;
    step();
    n_tests++;
    if (bus.state !== 2'b01 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL fault_recover got %h exp %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    bus.shutdown_in = 1; bus.estop_clear = 1;
    for (int i = 0; i < 30; i++) begin
      bus.app_alive = (i % 15 == 0);
      bus.restart_req = (i == 0);
      step();
    end
    n_tests++;
    if (bus.ack_n !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL areset_setup got %h exp %h", obs_vec(), exp_vec());
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs_vec() !== 13'h0800) begin
      n_fail++; $display("FAIL areset_immediate got %h exp %h", obs_vec(), 13'h0800);
    end
    do_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bus.enable      = ($urandom_range(0, 99) != 0);
      bus.app_alive   = ($urandom_range(0, 7) == 0);
      bus.restart_req = ($urandom_range(0, 29) == 0);
      bus.shutdown_in = ($urandom_range(0, 9) < 7);
      bus.estop_clear = ($urandom_range(0, 9) < 7);
      if (!bus.app_fault && $urandom_range(0, 199) == 0) bus.app_fault = 1;
      else if (bus.app_fault && $urandom_range(0, 9) == 0) bus.app_fault = 0;
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
    bus.app_fault = 0;
  endtask

  task automatic test_wrap();
    int kicks;
    kicks = 0;
    do_reset();
    bus.enable = 1;
    for (int i = 0; i < 256 * KC + 100 && kicks < 256; i++) begin
      bus.app_alive = (i % 10 == 0);
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL wrap cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      if (bus.wdg_kick) begin
        kicks++;
        if (kicks == 255 || kicks == 256) begin
          n_tests++;
          if (bus.kick_count !== 8'(kicks % 256)) begin
            n_fail++; $display("FAIL wrap_count got %0d exp %0d", bus.kick_count, kicks % 256);
          end
        end
      end
    end
    n_tests++;
    if (kicks != 256) begin
      n_fail++; $display("FAIL wrap_timeout got %0d kicks exp 256", kicks);
    end
  endtask

  initial begin
    bus.enable = 0; bus.app_alive = 0; bus.app_fault = 0;
    bus.restart_req = 0; bus.shutdown_in = 0; bus.estop_clear = 0;
    test_reset();
    test_kicking();
    test_stall();
    test_ack();
    test_ack_blocked();
    test_fault();
    test_async_reset();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/esd_heartbeat_initiator.md
Name: esd_heartbeat_initiator

Overview:
Supervised-side counterpart of the emergency shutdown controller. Generates the watchdog kick pulses the controller consumes, gated by application liveness. Issues a timed active-low ACK pulse on request, so the controller can leave shutdown once the E-STOPs are clear. Sits between the application/host logic and the controller's wdg_kick/ack_n inputs.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
KICK_PERIOD_US, 10000, kick interval in microseconds; KICK_CYCLES = CLK_HZ/1000000*KICK_PERIOD_US, minimum 4
ACK_CYCLES, 100, width of the ack_n low pulse in clocks, minimum 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = heartbeat service active
app_alive  in  1  1-cycle pulse from the application main loop
app_fault  in  1  level; application self-check failed
restart_req  in  1  1-cycle pulse requesting restart or ACK
shutdown_in  in  1  controller shutdown output, already synchronous
estop_clear  in  1  1 = both E-STOPs released, already synchronous
wdg_kick  out  1  1-cycle kick pulse to the controller
ack_n  out  1  active-low ACK to the controller
stalled  out  1  1 in STALLED
state  out  2  FSM state encoding
kick_count  out  8  kicks issued, wraps 255->0

Behaviour:
- Reset is asynchronous and active-low; all flops clear on rst_n=0 and on the clk edge only otherwise. Reset values: wdg_kick=0, ack_n=1, stalled=0, kick_count=0, state=IDLE (00), timers=0, alive_flag=0.
- States: IDLE=00, KICKING=01, ACKING=10, STALLED=11. All outputs are registered.
- alive_flag:
  - Set by app_alive.
  - Cleared by each issued kick, except that an app_alive in the same cycle as the kick keeps the flag set for the next interval.
  - Cleared on entry to KICKING.
- IDLE: no kicks, timer held at 0. enable=1 -> KICKING.
- KICKING:
  - kick_timer counts 0..KICK_CYCLES-1.
  - At KICK_CYCLES-1, if alive_flag=1 or app_alive=1: wdg_kick=1 for the next cycle only, kick_count+1, timer wraps to 0.
  - At KICK_CYCLES-1 with no liveness: -> STALLED, no kick.
- Any state except IDLE: app_fault=1 -> STALLED next cycle. This wins over a same-cycle kick or ACK start.
- KICKING -> ACKING on restart_req=1 with shutdown_in=1, estop_clear=1 and app_fault=0. Otherwise restart_req is ignored in KICKING.
- ACKING:
  - ack_n=0 for exactly ACK_CYCLES clocks, then ack_n=1 and -> KICKING.
  - The kick timer and kicks continue unchanged.
  - The pulse is never truncated by shutdown_in or estop_clear changes.
  - app_fault aborts: ack_n=1 immediately, -> STALLED.
- STALLED: no kicks, stalled=1. restart_req=1 with app_fault=0 -> KICKING, with timer=0 and alive_flag=0.
- enable=0 in any state -> IDLE next cycle, ack_n=1, no kick that cycle. kick_count is retained.
- Priority: enable=0 > app_fault > kick timeout > restart_req.
- Latency:
  - restart_req to first ack_n low: 1 cycle.
  - Timer expiry to wdg_kick high: 1 cycle.

Decomposition:
- Package esd_pkg holds:
  - the state typedef and encodings;
  - the KICK_CYCLES and ACK_CYCLES derivation functions;
  - the kick_count width constant.
- Natural sub-module: esd_interval_timer. A parameterised counter with clear, enable and terminal-count pulse, instanced once for the kick interval and once for the ACK width.

Test Plan:
1. Reset, then enable=1 with KICK_PERIOD_US=1 (50 cycles) and app_alive every 20 cycles -> wdg_kick pulses exactly every 50 cycles, 1 cycle wide; kick_count=5 after 250 cycles.
2. Stop app_alive -> one further kick at most, then state=11 and stalled=1, with no wdg_kick for 500 cycles. restart_req -> state=01 and kicks resume.
3. shutdown_in=1, estop_clear=1, restart_req -> ack_n low for exactly ACK_CYCLES=100 clocks, starting 1 cycle after the request; kicks continue during the pulse; then state=01.
4. restart_req with estop_clear=0, or with shutdown_in=0 -> ack_n stays 1 and state stays 01.
5. app_fault asserted mid-ACK (cycle 40) -> ack_n=1 and state=11 next cycle. restart_req while app_fault=1 is ignored.
6. rst_n low mid-ACK and mid-count -> ack_n=1, wdg_kick=0, kick_count=0 and state=00 immediately, without waiting for a clock edge. kick_count wraps 255->0 after 256 kicks.
